ksa_multiword_sequencer: RTL



---
 rtl/ksa_multiword_sequencer.sv | 92 +++++++++
 1 files changed

// File: rtl/ksa_multiword_sequencer.sv
// Multi-word add/subtract sequencer driving one external 8-bit adder, one byte per cycle, LSB first.
// The inter-byte carry is chained through carry_reg; cout and signed overflow cover the full-width result.
module ksa_multiword_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [8*WORDS-1:0]   a,
  input  logic [8*WORDS-1:0]   b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [8*WORDS-1:0]   result,
  output logic                 cout,
  output logic                 overflow,
  output logic [7:0]           add_x,
  output logic [7:0]           add_y,
  output logic                 add_cin,
  input  logic [7:0]           add_sum,
  input  logic                 add_cout
);

  localparam int N  = 8 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [IW+2:0]   base;
  logic [N-1:0]    a_reg;
  logic [N-1:0]    b_reg;
  logic            sub_reg;
  logic            carry_reg;

  assign ready = (state == IDLE) || (state == DONE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  // Adder operands come only from registers, so add_sum never loops back into them.
  assign base    = {idx, 3'b000};
  assign add_x   = a_reg[base +: 8];
  assign add_y   = b_reg[base +: 8] ^ {8{sub_reg}};
  assign add_cin = carry_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      carry_reg <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            sub_reg   <= sub;
            carry_reg <= sub;
            idx       <= '0;
            result    <= '0;
            state     <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          result[base +: 8] <= add_sum;
          carry_reg         <= add_cout;
          // The top slice's sign bits decide two's-complement overflow for the whole word.
          if (idx == LAST) begin
            state    <= DONE;
            cout     <= add_cout;
            overflow <= (add_x[7] == add_y[7]) && (add_sum[7] != add_x[7]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
